quantize_block: RTL and testbench

Sequential forward quantizer for the compression path. It sits between the forward 2-D DCT and the entropy coder, and is the inverse of the dequantization step used on decompression. On each `start_block` it captures an 8×8 block of DCT coefficients and divides each one by its quantization-table entry, rounding to nearest. It then saturates each result to `COEFF_WIDTH` bits and presents the whole quantized block at once with a one-cycle `block_done` pulse.

---
 rtl/quantize_block_if.sv | 29 ++
 rtl/quantize_block.sv | 139 +++++++++++++
 tb/tb_quantize_block.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/quantize_block_if.sv
// Block-level bus between the DCT stage and the forward quantizer:
// the start request with its coefficient block, and the quantized result with its status.
interface quantize_block_if #(
  parameter int BLOCK_SIZE  = 8,
  parameter int DCT_WIDTH   = 16,
  parameter int COEFF_WIDTH = 9
);
  logic                          start_block;
  logic signed [DCT_WIDTH-1:0]   dct_coeffs       [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [COEFF_WIDTH-1:0] quantized_coeffs [BLOCK_SIZE][BLOCK_SIZE];
  logic                          block_done;
  logic                          busy;

  modport master (
    output start_block,
    output dct_coeffs,
    input  quantized_coeffs,
    input  block_done,
    input  busy
  );

  modport slave (
    input  start_block,
    input  dct_coeffs,
    output quantized_coeffs,
    output block_done,
    output busy
  );
endinterface

// File: rtl/quantize_block.sv
// Sequential forward quantizer: one coefficient per cycle through a 2-stage pipeline,
// dividing by the JPEG luminance table with round-half-away-from-zero and saturation.
module quantize_block #(
  parameter int BLOCK_SIZE  = 8,
  parameter int DCT_WIDTH   = 16,
  parameter int COEFF_WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  quantize_block_if.slave  bus
);
  localparam int NUM   = BLOCK_SIZE * BLOCK_SIZE;
  localparam int AW    = DCT_WIDTH + 1;
  localparam int SHIFT = AW + 7;
  localparam int PW    = AW + SHIFT;
  localparam logic [AW-1:0] POS_LIM = AW'((1 << (COEFF_WIDTH - 1)) - 1);
  localparam logic [AW-1:0] NEG_LIM = AW'(1 << (COEFF_WIDTH - 1));

  localparam int QTABLE [NUM] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                        r_state;
  logic [5:0]                    r_cnt;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_v;
  logic [5:0]                    r_k;
  logic signed [DCT_WIDTH-1:0]   r_x;
  logic [SHIFT-1:0]              r_recip;
  logic [6:0]                    r_half;
  logic signed [DCT_WIDTH-1:0]   r_inBuf  [NUM];
  logic [COEFF_WIDTH-1:0]        r_resBuf [NUM];

  logic [SHIFT-1:0]              w_recipRom [NUM];
  logic [6:0]                    w_halfRom  [NUM];
  logic                          w_accept;
  logic                          w_neg;
  logic [AW-1:0]                 w_ext;
  logic [AW-1:0]                 w_abs;
  logic [AW-1:0]                 w_num;
  logic [PW-1:0]                 w_prod;
  logic [AW-1:0]                 w_mag;
  logic [COEFF_WIDTH-1:0]        w_sat;
  logic [COEFF_WIDTH-1:0]        w_finalBuf [NUM];

  // Reciprocal ceil(2^SHIFT/Q): numerator < 2^AW and error < Q < 2^7 keeps N*m>>SHIFT exact.
  for (genvar g = 0; g < NUM; g++) begin : g_rom
    assign w_recipRom[g] = SHIFT'(((64'd1 << SHIFT) + 64'(QTABLE[g]) - 64'd1) / 64'(QTABLE[g]));
    assign w_halfRom[g]  = 7'(QTABLE[g] / 2);
  end

  assign w_accept       = (r_state == IDLE) && bus.start_block;
  assign bus.busy       = r_busy;
  assign bus.block_done = r_done;

  always_comb begin
    w_neg  = r_x[DCT_WIDTH-1];
    w_ext  = {r_x[DCT_WIDTH-1], r_x};
    w_abs  = w_neg ? (~w_ext + AW'(1)) : w_ext;
    w_num  = w_abs + AW'(r_half);
    w_prod = PW'(w_num) * PW'(r_recip);
    w_mag  = AW'(w_prod >> SHIFT);
    if (!w_neg) begin
      w_sat = (w_mag > POS_LIM) ? COEFF_WIDTH'(POS_LIM) : COEFF_WIDTH'(w_mag);
    end else begin
      w_sat = (w_mag > NEG_LIM) ? COEFF_WIDTH'(-NEG_LIM) : COEFF_WIDTH'(-w_mag);
    end
  end

  // The last result bypasses the buffer so the published block is complete on the done edge.
  always_comb begin
    for (int i = 0; i < NUM; i++) w_finalBuf[i] = r_resBuf[i];
    if (r_v) w_finalBuf[r_k] = w_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_v     <= 1'b0;
      for (int r = 0; r < BLOCK_SIZE; r++)
        for (int c = 0; c < BLOCK_SIZE; c++)
          bus.quantized_coeffs[r][c] <= '0;
    end else begin
      r_done <= 1'b0;
      r_v    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_block) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_v   <= 1'b1;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(NUM - 1)) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          for (int r = 0; r < BLOCK_SIZE; r++)
            for (int c = 0; c < BLOCK_SIZE; c++)
              bus.quantized_coeffs[r][c] <= w_finalBuf[r * BLOCK_SIZE + c];
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < BLOCK_SIZE; r++)
        for (int c = 0; c < BLOCK_SIZE; c++)
          r_inBuf[r * BLOCK_SIZE + c] <= bus.dct_coeffs[r][c];
    end
    if (r_state == RUN) begin
      r_x     <= r_inBuf[r_cnt];
      r_k     <= r_cnt;
      r_recip <= w_recipRom[r_cnt];
      r_half  <= w_halfRom[r_cnt];
    end
    if (r_v) r_resBuf[r_k] <= w_sat;
  end
endmodule

// File: tb/tb_quantize_block.sv
// Scoreboard bench for quantize_block: stimulus pushes reference results per accepted block,
// an independent monitor pops and compares on every block_done.
module tb_quantize_block;
  localparam int BS  = 8;
  localparam int DW  = 16;
  localparam int CW  = 9;
  localparam int NUM = BS * BS;
  localparam int LAT = 65;

  localparam int QT [NUM] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   total = 0;
  int   bad = 0;
  int   blkNo = 0;
  int   curBlk [NUM];
  int   expQ [$];
  int   cycQ [$];

  quantize_block_if #(.BLOCK_SIZE(BS), .DCT_WIDTH(DW), .COEFF_WIDTH(CW)) ifc ();

  quantize_block #(.BLOCK_SIZE(BS), .DCT_WIDTH(DW), .COEFF_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Rounded division straight from the quantizer definition, then clamp to the output range.
  function automatic int refQuant(input int x, input int q);
    int a, m, r;
    a = (x < 0) ? -x : x;
    m = (a + q / 2) / q;
    r = (x < 0) ? -m : m;
    if (r > (1 << (CW - 1)) - 1) r = (1 << (CW - 1)) - 1;
    if (r < -(1 << (CW - 1))) r = -(1 << (CW - 1));
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkResetState(input string name);
    int nz = 0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        if (ifc.quantized_coeffs[r][c] !== '0) nz++;
    checkOutput({name, "_nonzero_outs"}, nz, 0);
    checkOutput({name, "_done"}, int'(ifc.block_done), 0);
    checkOutput({name, "_busy"}, int'(ifc.busy), 0);
  endtask

  // Waits for the DUT to be idle, then presents curBlk for exactly one accepting edge.
  task automatic applyStimulus(input int gap);
    int waited = 0;
    @(negedge clk);
    while (ifc.busy === 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (ifc.busy !== 1'b0) begin
      checkOutput("idle_wait_busy", int'(ifc.busy), 0);
      return;
    end
    repeat (gap) @(negedge clk);
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        ifc.dct_coeffs[r][c] = DW'(curBlk[r * BS + c]);
    ifc.start_block = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM; i++) expQ.push_back(refQuant(curBlk[i], QT[i]));
    cycQ.push_back(cycle + LAT);
    ifc.start_block = 1'b0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        ifc.dct_coeffs[r][c] = DW'($urandom);
  endtask

  task automatic clearBlock();
    for (int i = 0; i < NUM; i++) curBlk[i] = 0;
  endtask

  task automatic randomBlock();
    int style;
    style = $urandom_range(0, 2);
    for (int i = 0; i < NUM; i++) begin
      case (style)
        0:       curBlk[i] = int'($signed(16'($urandom)));
        1:       curBlk[i] = int'($urandom_range(0, 4096)) - 2048;
        default: curBlk[i] = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom))) : 0;
      endcase
    end
  endtask

  // Monitor: pops one expected block per block_done and checks data, latency, busy span and hold.
  initial begin : monitor
    int lastOut [NUM];
    int run;
    int holdOk;
    int firstIdx, act, exp;
    run = 0;
    holdOk = 1;
    for (int i = 0; i < NUM; i++) lastOut[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        run = 0;
        holdOk = 1;
        for (int i = 0; i < NUM; i++) lastOut[i] = 0;
      end else if (ifc.block_done === 1'b1) begin
        blkNo++;
        checkOutput($sformatf("blk%0d_hold", blkNo), holdOk, 1);
        checkOutput($sformatf("blk%0d_busy_at_done", blkNo), int'(ifc.busy), 0);
        if (cycQ.size() == 0) begin
          checkOutput($sformatf("blk%0d_unexpected_done", blkNo), 1, 0);
        end else begin
          checkOutput($sformatf("blk%0d_latency_cycle", blkNo), cycle, cycQ.pop_front());
          checkOutput($sformatf("blk%0d_busy_cycles", blkNo), run, LAT);
          firstIdx = 0;
          for (int i = NUM - 1; i >= 0; i--)
            if (int'(ifc.quantized_coeffs[i / BS][i % BS]) != expQ[i]) firstIdx = i;
          act = int'(ifc.quantized_coeffs[firstIdx / BS][firstIdx % BS]);
          exp = expQ[firstIdx];
          checkOutput($sformatf("blk%0d_data_k%0d", blkNo, firstIdx), act, exp);
          for (int i = 0; i < NUM; i++) lastOut[i] = expQ.pop_front();
        end
        run = 0;
        holdOk = 1;
      end else begin
        if (ifc.busy === 1'b1) run++;
        for (int i = 0; i < NUM; i++)
          if (int'(ifc.quantized_coeffs[i / BS][i % BS]) != lastOut[i]) holdOk = 0;
      end
    end
  end

  initial begin : stimulus
    int idxs [7] = '{0, 0, 1, 1, 1, 63, 63};
    int vals [7] = '{1000, -1000, 5, 6, -6, -148, -149};
    int waited;
    ifc.start_block = 1'b0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        ifc.dct_coeffs[r][c] = '0;

    repeat (3) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;

    clearBlock();
    applyStimulus(0);

    for (int t = 0; t < 7; t++) begin
      clearBlock();
      curBlk[idxs[t]] = vals[t];
      applyStimulus(t % 2);
    end

    clearBlock();
    curBlk[0] = 32767;
    curBlk[2] = -32768;
    applyStimulus(0);

    // A start pulse mid-run with different data must not disturb the block in flight.
    randomBlock();
    applyStimulus(0);
    repeat (10) @(negedge clk);
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        ifc.dct_coeffs[r][c] = 16'sd1234;
    ifc.start_block = 1'b1;
    @(negedge clk);
    ifc.start_block = 1'b0;

    // Abort a block 30 cycles in; its expectation is withdrawn.
    randomBlock();
    applyStimulus(0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NUM; i++) void'(expQ.pop_back());
    void'(cycQ.pop_back());
    repeat (2) @(negedge clk);
    checkResetState("midreset");
    rst_n = 1'b1;
    randomBlock();
    applyStimulus(1);

    for (int b = 0; b < 1000; b++) begin
      randomBlock();
      applyStimulus($urandom_range(0, 3));
    end

    waited = 0;
    while (cycQ.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pending_blocks", cycQ.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
